// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and inverse-cipher state transforms.
// The 128-bit state is column-major: byte i is bits [127-8i -: 8], at row i%4, column i/4.
package aes_pkg;

    localparam int AES_BLK = 128;
    localparam int NR_128  = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } inv_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r moves right by r byte positions: new[r][c] = old[r][c-r].
    function automatic logic [AES_BLK-1:0] inv_shift_rows(input logic [AES_BLK-1:0] s);
        logic [AES_BLK-1:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [AES_BLK-1:0] inv_mix_columns(input logic [AES_BLK-1:0] s);
        logic [AES_BLK-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// Sixteen parallel inverse S-box lookups, built from the inverse affine map followed
// by the GF(2^8) multiplicative inverse rather than a stored 256-entry table.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    // a^254 == a^-1 in GF(2^8), with 0 mapping to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a7, a14, a15, a30, a60, a120, a127;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a7   = gf_mul(a6, a);
        a14  = gf_mul(a7, a7);
        a15  = gf_mul(a14, a);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a127 = gf_mul(a120, a7);
        return gf_mul(a127, a127);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by index
// from an external key-schedule table, valid/ready handshake on both sides.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [3:0] NR_IDX   = 4'(NR);
    localparam logic [3:0] RND_INIT = 4'(NR - 1);

    inv_state_e   state_q;
    logic [3:0]   rnd_q;
    logic [127:0] st_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] st_round_d;
    logic [127:0] st_final_d;

    // One InvSubBytes instance serves both the middle rounds and the last round.
    assign isr = inv_shift_rows(st_q);

    inv_sub_bytes u_inv_sub_bytes (
        .data_i (isr),
        .data_o (isb)
    );

    assign st_round_d = inv_mix_columns(isb ^ rk_data);
    assign st_final_d = isb ^ rk_data;

    always_comb begin
        rk_idx = NR_IDX;
        case (state_q)
            S_ROUND: rk_idx = rnd_q;
            S_FINAL: rk_idx = 4'd0;
            default: rk_idx = NR_IDX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rnd_q       <= RND_INIT;
            st_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        st_q       <= in_data ^ rk_data;
                        rnd_q      <= RND_INIT;
                        state_q    <= S_ROUND;
                        in_ready_q <= 1'b0;
                    end
                end
                S_ROUND: begin
                    st_q <= st_round_d;
                    if (rnd_q == 4'd1) state_q <= S_FINAL;
                    else               rnd_q   <= rnd_q - 4'd1;
                end
                S_FINAL: begin
                    st_q        <= st_final_d;
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = st_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: known-answer table, handshake corner cases and
// random round trips against a forward AES-128 model with its own key expansion.
module tb_aes_inv_cipher_iter;

    localparam int NR = 10;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic [127:0] rk_tbl [0:NR];
    logic [7:0]   sbox [0:255];
    logic [127:0] cur_exp;
    logic [127:0] sb_q [$];
    int           xfer_cyc [$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [127:0] pd = '0;

    aes_inv_cipher_iter #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk_data = (rk_idx <= 4'(NR)) ? rk_tbl[rk_idx] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 0; aa = a; bb = b;
        while (bb != 0) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = b;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [0:4*NR+3];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tbl[0][127-8*i -: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int rw = 0; rw < 4; rw++)
                for (int c = 0; c < 4; c++) s[rw+4*c] = t[rw+4*((c+rw)%4)];
            if (r != NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
                    s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tbl[r][127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (rk_idx > 4'(NR)) begin
                n_cmp++; n_err++;
                $display("FAIL rk_idx_range: got %0d limit %0d", rk_idx, NR);
            end
            if (pv && !pr) begin
                check("hold_valid", 128'(out_valid), 128'd1);
                check("hold_data", out_data, pd);
            end
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
            if (out_valid && out_ready) begin
                xfer_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out: got %h with nothing expected", out_data);
                end else begin
                    check("out_data", out_data, sb_q.pop_front());
                end
            end
            pv <= out_valid;
            pr <= out_ready;
            pd <= out_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] ct, input logic [127:0] exp, input int budget,
                        input logic keep, output int waited);
        logic ok;
        in_valid = 1'b1; in_data = ct; cur_exp = exp;
        ok = 1'b0; waited = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            if (!ok) waited++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", budget);
        end
        if (!keep) in_valid = 1'b0;
    endtask

    // Called just after the accept edge: checks the rk_idx walk and the accept-to-valid latency.
    task automatic latency_check();
        logic seq_ok;
        int   k;
        int   exp_rk;
        seq_ok = 1'b1; k = 0;
        while (!out_valid && k < 3*NR) begin
            if (k <= NR-1) begin
                exp_rk = (k < NR-1) ? NR-1-k : 0;
                if (rk_idx != 4'(exp_rk)) seq_ok = 1'b0;
            end
            @(posedge clk); #1; k++;
        end
        check("latency", 128'(k), 128'(NR));
        check("rk_seq", 128'(seq_ok), 128'd1);
    endtask

    task automatic drain(input int budget, input logic rnd_ready);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || out_valid) && k < budget) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1; k++;
        end
        if (sb_q.size() != 0 || out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d results pending after %0d cycles, required 0", sb_q.size(), budget);
        end
        out_ready = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t         vecs [3];
        logic [127:0] pts [4];
        logic [127:0] cts [4];
        logic [127:0] key, pt;
        int           w;
        logic         seen;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cur_exp = '0;
        build_sbox();
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
        set_key(vecs[0].key);

        // Reset state, with a block offered during reset that must not be taken.
        in_valid = 1'b1; in_data = vecs[0].ct;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'(NR));
        rst = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (NR + 3) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_wins_no_out", 128'(seen), 128'd0);

        // Known-answer table.
        for (int v = 0; v < 3; v++) begin
            set_key(vecs[v].key);
            check("rk_idle", 128'(rk_idx), 128'(NR));
            send(vecs[v].ct, vecs[v].pt, 4, 1'b0, w);
            latency_check();
            drain(50, 1'b0);
        end

        // Backpressure: result held 20 cycles while input pulses are ignored.
        set_key(vecs[0].key);
        out_ready = 1'b0;
        send(vecs[0].ct, vecs[0].pt, 4, 1'b0, w);
        for (int k = 0; k < 3*NR && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0]; in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cur_exp = '0;
            if (in_ready) seen = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_in_ready_low", 128'(seen), 128'd0);
        check("bp_valid", 128'(out_valid), 128'd1);
        check("bp_data", out_data, vecs[0].pt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 128'(in_ready), 128'd1);
        check("bp_idle_valid", 128'(out_valid), 128'd0);
        set_key(vecs[1].key);
        send(vecs[1].ct, vecs[1].pt, 1, 1'b0, w);
        check("bp_next_accept_wait", 128'(w), 128'd0);
        latency_check();
        drain(50, 1'b0);

        // Back-to-back with in_valid held high: out_valid pulses separated by NR+1 low cycles.
        set_key(vecs[0].key);
        for (int i = 0; i < 4; i++) begin
            pts[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            cts[i] = enc(pts[i]);
        end
        xfer_cyc.delete();
        for (int i = 0; i < 4; i++) send(cts[i], pts[i], 3*NR, 1'b1, w);
        in_valid = 1'b0;
        drain(100, 1'b0);
        check("b2b_count", 128'(xfer_cyc.size()), 128'd4);
        for (int i = 1; i < xfer_cyc.size(); i++)
            check("b2b_gap", 128'(xfer_cyc[i] - xfer_cyc[i-1] - 1), 128'(NR + 1));

        // Reset in the middle of a block, at round counter 5.
        send(vecs[0].ct, vecs[0].pt, 4, 1'b0, w);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid_rk_idx", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_out_data", out_data, 128'd0);
        send(vecs[0].ct, vecs[0].pt, 4, 1'b0, w);
        latency_check();
        drain(50, 1'b0);

        // Random round trips with random downstream stalls.
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_key(key);
            send(enc(pt), pt, 4, 1'b0, w);
            drain(200, 1'b1);
        end

        check("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
